// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi decoder scheduler.
package viterbi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } vit_state_e;

  localparam int VIT_IN_W    = 8;
  localparam int VIT_OUT_W   = 4;
  localparam int VIT_DEC_LAT = 6;

endpackage

// File: rtl/viterbi_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 upward with wrap-around and returns
// a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_vld
);

  int   idx_s;
  logic hit_s;

  // First requester after ptr wins; the pointer itself has lowest priority
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    idx_s     = 0;
    hit_s     = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx_s        = (int'(ptr) + i) % N_REQ;
      hit_s        = ~grant_vld & req[idx_s];
      grant[idx_s] = hit_s;
      grant_id     = hit_s ? ID_W'(idx_s) : grant_id;
      grant_vld    = grant_vld | hit_s;
    end
  end

endmodule

// File: rtl/viterbi_scheduler.sv
// Shares one external Viterbi decoder among N_REQ requesters (round-robin).
// Optional RUN timeout abort is enabled by defining VITERBI_SCHED_TIMEOUT_EN.
module viterbi_scheduler
  import viterbi_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [VIT_IN_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rsp_valid,
  output logic [VIT_OUT_W-1:0]      rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_err,
  input  logic                      rsp_ready,
  output logic                      dec_start,
  output logic [VIT_IN_W-1:0]       dec_in,
  input  logic [VIT_OUT_W-1:0]      dec_out,
  input  logic                      dec_ready,
  output logic                      busy
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_RESP = ST_RESP;

  // Unsupported configurations elaborate this marker block
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT <= VIT_DEC_LAT) begin : g_cfg_unsupported
  end

  logic [1:0]          state_r;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [ID_W-1:0]     cur_id_r;
  logic [N_REQ-1:0]    grant_s;
  logic [ID_W-1:0]     grant_id_s;
  logic                grant_vld_s;
  logic [VIT_IN_W-1:0] sel_word_s;
  logic                tmo_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_id  (grant_id_s),
    .grant_vld (grant_vld_s)
  );

  assign req_ready  = (state_r == S_IDLE) ? grant_s : '0;
  assign sel_word_s = req_data[VIT_IN_W*grant_id_s +: VIT_IN_W];

`ifdef VITERBI_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             rsp_err_r;

  // Counts RUN cycles; cleared whenever the decoder is not running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if (state_r == S_RUN) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  assign tmo_s = (state_r == S_RUN) && (tmo_cnt_r == TMO_W'(TIMEOUT - 1));

  // Error flag is captured on the same edge as rsp_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_r <= 1'b0;
    end else if ((state_r == S_RUN) && (dec_ready || tmo_s)) begin
      rsp_err_r <= ~dec_ready;
    end else begin
      rsp_err_r <= rsp_err_r;
    end
  end

  assign rsp_err = rsp_err_r;
`else
  assign tmo_s   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Sequencer: accept in IDLE, run the decoder, hold the result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      rr_ptr_r  <= ID_W'(N_REQ - 1);
      cur_id_r  <= '0;
      dec_start <= 1'b0;
      dec_in    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (grant_vld_s) begin
            dec_in    <= sel_word_s;
            cur_id_r  <= grant_id_s;
            rr_ptr_r  <= grant_id_s;
            dec_start <= 1'b1;
            busy      <= 1'b1;
            state_r   <= S_RUN;
          end
        end
        S_RUN: begin
          if (dec_ready || tmo_s) begin
            rsp_data  <= dec_ready ? dec_out : '0;
            rsp_id    <= cur_id_r;
            rsp_valid <= 1'b1;
            dec_start <= 1'b0;
            state_r   <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= S_IDLE;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          dec_start <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_scheduler.sv
// Self-checking bench for viterbi_scheduler: directed table, multi-cycle corner
// sequences and random traffic against a transaction-level reference model.
module tb_viterbi_scheduler;

  localparam int N       = 4;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_ready;
  logic         rsp_valid;
  logic [3:0]   rsp_data;
  logic [1:0]   rsp_id;
  logic         rsp_err;
  logic         rsp_ready;
  logic         dec_start;
  logic [7:0]   dec_in;
  logic [3:0]   dec_out;
  logic         dec_ready;
  logic         busy;

  always #5 clk = ~clk;

  viterbi_scheduler #(.N_REQ(N), .ID_W(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .dec_start(dec_start), .dec_in(dec_in), .dec_out(dec_out),
    .dec_ready(dec_ready), .busy(busy)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  // Rate-1/2 encoder: pair k = {s1^s2, b^s1} at bits [2k+1:2k]
  function automatic logic [7:0] ref_encode(input logic [3:0] m);
    logic s1, s2, b;
    logic [7:0] c;
    s1 = 1'b0; s2 = 1'b0; c = 8'h00;
    for (int k = 0; k < 4; k++) begin
      b = m[k];
      c[2*k]   = b ^ s1;
      c[2*k+1] = s1 ^ s2;
      s2 = s1;
      s1 = b;
    end
    return c;
  endfunction

  // Maximum-likelihood decode by exhaustive search (ties -> lowest message)
  function automatic logic [3:0] ref_decode(input logic [7:0] w);
    int best_d, d;
    logic [3:0] best;
    best_d = 99; best = 4'h0;
    for (int m = 0; m < 16; m++) begin
      d = $countones(ref_encode(4'(m)) ^ w);
      if (d < best_d) begin
        best_d = d;
        best   = 4'(m);
      end
    end
    return best;
  endfunction

  // Decoder stand-in: Ready six edges after start rises, cleared when start drops
  int   stub_cnt;
  logic stub_hang = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_cnt <= 0; dec_ready <= 1'b0; dec_out <= 4'h0;
    end else if (!dec_start) begin
      stub_cnt <= 0; dec_ready <= 1'b0; dec_out <= 4'h0;
    end else begin
      if (stub_cnt < 6) stub_cnt <= stub_cnt + 1;
      if (stub_cnt >= 5 && !stub_hang) begin
        dec_ready <= 1'b1;
        dec_out   <= ref_decode(dec_in);
      end
    end
  end

  // Reference model state (transaction level)
  bit         m_busy;
  int         m_age, m_lat, m_ptr, m_id;
  logic [7:0] m_word;
  logic [3:0] m_exp;
  bit         m_err;
  int         acc_id_q[$];
  int         acc_cyc_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    for (int i = 1; i <= N; i++) begin
      if (req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_age = 0; m_lat = LAT; m_ptr = N - 1; m_id = 0;
    m_word = 8'h00; m_exp = 4'h0; m_err = 1'b0;
  endtask

  task automatic check_outputs();
    int g;
    logic [3:0] exp_rr;
    g = model_grant();
    exp_rr = (!m_busy && g >= 0) ? 4'(1 << g) : 4'h0;
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("dec_start", 32'(dec_start), 32'(m_busy && m_age < m_lat));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= m_lat));
    if (m_busy) chk("dec_in", 32'(dec_in), 32'(m_word));
    if (m_busy && m_age >= m_lat) begin
      chk("rsp_data", 32'(rsp_data), 32'(m_exp));
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    for (int k = 0; k < N; k++) begin
      if (req_ready[k] && req_valid[k]) begin
        acc_id_q.push_back(k);
        acc_cyc_q.push_back(cyc);
      end
    end
  endtask

  task automatic model_edge();
    int g;
    cyc++;
    if (!m_busy) begin
      g = model_grant();
      if (g >= 0) begin
        m_busy = 1'b1; m_age = 0; m_ptr = g; m_id = g;
        m_word = req_data[8*g +: 8];
        m_lat  = stub_hang ? TIMEOUT : LAT;
        m_exp  = stub_hang ? 4'h0 : ref_decode(m_word);
        m_err  = stub_hang;
      end
    end else if (m_age >= m_lat && rsp_ready) begin
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  typedef struct {
    int         id;
    logic [7:0] word;
    logic [3:0] exp_data;
  } vec_t;

  vec_t vecs[5];
  int   lat;

  initial begin
    vecs[0] = '{0, 8'h00, 4'h0};
    vecs[1] = '{2, 8'hB4, 4'h2};
    vecs[2] = '{3, 8'h09, 4'hF};
    vecs[3] = '{1, 8'h2D, 4'h1};
    vecs[4] = '{0, 8'h40, 4'h8};

    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dec_start", 32'(dec_start), 32'd0);
    chk("rst_dec_in", 32'(dec_in), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // Directed single-request vectors with explicit latency check
    foreach (vecs[v]) begin
      req_valid = 4'(1 << vecs[v].id);
      req_data = $urandom;
      req_data[8*vecs[v].id +: 8] = vecs[v].word;
      cycle();
      req_valid = '0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
        cycle();
        if (lat < 0 && rsp_valid) begin
          lat = k;
          chk("vec_rsp_data", 32'(rsp_data), 32'(vecs[v].exp_data));
          chk("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
        end
      end
      chk("vec_latency", 32'(lat), 32'(LAT));
    end

    // Backpressure: rsp_ready low for 5 RESP cycles while others request
    rsp_ready = 1'b0; req_valid = 4'b1010; req_data = $urandom;
    run(LAT + 1 + 5);
    rsp_ready = 1'b1;
    run(2);
    req_valid = '0;
    run(12);

    // Reset three cycles after an accept discards the job
    req_valid = 4'b0001; req_data = $urandom;
    cycle();
    req_valid = '0;
    run(3);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_dec_start", 32'(dec_start), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    cycle();
    rst = 1'b0;
    run(10);

    // All requesters continuously valid: fair rotation from requester 0
    acc_id_q.delete(); acc_cyc_q.delete();
    req_valid = 4'b1111; req_data = $urandom;
    run(46);
    req_valid = '0;
    run(12);
    chk("rr_count", 32'(acc_id_q.size() >= 5), 32'd1);
    if (acc_id_q.size() >= 5) begin
      chk("rr_g0", 32'(acc_id_q[0]), 32'd0);
      chk("rr_g1", 32'(acc_id_q[1]), 32'd1);
      chk("rr_g2", 32'(acc_id_q[2]), 32'd2);
      chk("rr_g3", 32'(acc_id_q[3]), 32'd3);
      chk("rr_g4", 32'(acc_id_q[4]), 32'd0);
      for (int i = 1; i < 5; i++)
        chk("rr_spacing", 32'(acc_cyc_q[i] - acc_cyc_q[i-1] >= 9), 32'd1);
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_data  = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_valid = '0; rsp_ready = 1'b1;
    run(20);

`ifdef VITERBI_SCHED_TIMEOUT_EN
    // Decoder never answers: abort after TIMEOUT RUN cycles
    stub_hang = 1'b1;
    req_valid = 4'b0100; req_data = $urandom;
    cycle();
    req_valid = '0;
    run(TIMEOUT + 4);
    stub_hang = 1'b0;
    run(4);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
